param_shift_reg: RTL and testbench

- Parametrised successor to the single-bit master-slave storage cell: a DEPTH-stage by WIDTH-bit universal shift register.
- Supports hold, shift-up, shift-down and parallel-load modes, with a fill counter.
- Serves as the generic staging / delay / serialiser element for datapath blocks.
- Fully synchronous: one clock edge, one reset.

---
 rtl/param_shift_reg.sv | 110 +++++++++++
 tb/tb_param_shift_reg.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/param_shift_reg.sv
// param_shift_reg: DEPTH-stage x WIDTH-bit universal shift register with a
// saturating fill counter. Modes: hold, shift-up, shift-down, parallel load.
// Stage i of par_in/par_out lives at bits [i*WIDTH +: WIDTH].
// Optional build macro SHIFT_REG_ROTATE_EN: when defined, rot=1 turns shifts
// into rotations; when undefined, rot is accepted and ignored.
module param_shift_reg #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int FW = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic [1:0]             mode,
  input  logic                   rot,
  input  logic [WIDTH-1:0]       sin_lo,
  input  logic [WIDTH-1:0]       sin_hi,
  input  logic [DEPTH*WIDTH-1:0] par_in,
  output logic [DEPTH*WIDTH-1:0] par_out,
  output logic [WIDTH-1:0]       sout_lo,
  output logic [WIDTH-1:0]       sout_hi,
  output logic [FW-1:0]          fill,
  output logic                   full
);

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_UP   = 2'b01;
  localparam logic [1:0] MODE_DOWN = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  localparam logic [FW-1:0] FILL_MAX = FW'(DEPTH);

  logic [WIDTH-1:0] r_stage [DEPTH];
  logic [FW-1:0]    r_fill;

  logic [WIDTH-1:0] w_next_stage [DEPTH];
  logic [FW-1:0]    w_next_fill;
  logic [FW-1:0]    w_fill_inc;
  logic [WIDTH-1:0] w_up_in;
  logic [WIDTH-1:0] w_down_in;

  // Fill advances by one per shift and saturates at DEPTH.
  assign w_fill_inc = (r_fill == FILL_MAX) ? r_fill : r_fill + FW'(1);

`ifdef SHIFT_REG_ROTATE_EN
  // Word entering each end: the serial input, or the word leaving the other end when rotating.
  assign w_up_in   = rot ? r_stage[DEPTH-1] : sin_lo;
  assign w_down_in = rot ? r_stage[0]       : sin_hi;
`else
  logic w_unused_rot;
  assign w_unused_rot = rot;
  assign w_up_in      = sin_lo;
  assign w_down_in    = sin_hi;
`endif

  // Next-state selection for the stage array and the fill counter.
  always_comb begin
    // NOTE: every target gets a default first so no path through the case leaves it unassigned and infers a latch.
    w_next_stage = r_stage;
    w_next_fill  = r_fill;
    // en is tested first, so an X on mode while disabled cannot reach the state.
    if (en) begin
      case (mode)
        MODE_UP: begin
          for (int i = 1; i < DEPTH; i++) w_next_stage[i] = r_stage[i-1];
          w_next_stage[0] = w_up_in;
          w_next_fill     = w_fill_inc;
        end
        MODE_DOWN: begin
          for (int i = 0; i < DEPTH - 1; i++) w_next_stage[i] = r_stage[i+1];
          w_next_stage[DEPTH-1] = w_down_in;
          w_next_fill           = w_fill_inc;
        end
        MODE_LOAD: begin
          for (int i = 0; i < DEPTH; i++) w_next_stage[i] = par_in[i*WIDTH +: WIDTH];
          w_next_fill = FILL_MAX;
        end
        MODE_HOLD: ;
        default: ;
      endcase
    end
  end

  // State registers with synchronous active-low reset taking priority over all modes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the stage array is cleared on reset because par_out/sout_* must read 0 afterwards; it is register storage, not a RAM.
      r_stage <= '{default: '0};
      r_fill  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every stage samples the pre-edge contents of its neighbour.
      r_stage <= w_next_stage;
      r_fill  <= w_next_fill;
    end
  end

  // Outputs come straight from registers (full from a register compare).
  genvar g;
  generate
    for (g = 0; g < DEPTH; g++) begin : g_pack
      assign par_out[g*WIDTH +: WIDTH] = r_stage[g];
    end
  endgenerate

  assign sout_lo = r_stage[0];
  assign sout_hi = r_stage[DEPTH-1];
  assign fill    = r_fill;
  assign full    = (r_fill == FILL_MAX);

endmodule

// File: tb/tb_param_shift_reg.sv
// tb_param_shift_reg: directed plan steps plus a random phase, checked against
// a queue-based reference model of the shift register.
module tb_param_shift_reg;

  localparam int W  = 8;
  localparam int D  = 4;
  localparam int FW = $clog2(D + 1);

  logic           clk;
  logic           rst_n;
  logic           en;
  logic [1:0]     mode;
  logic           rot;
  logic [W-1:0]   sin_lo;
  logic [W-1:0]   sin_hi;
  logic [D*W-1:0] par_in;
  logic [D*W-1:0] par_out;
  logic [W-1:0]   sout_lo;
  logic [W-1:0]   sout_hi;
  logic [FW-1:0]  fill;
  logic           full;

  int errors = 0;
  int checks = 0;

  // Reference model: q[0] is stage 0; shift-up pushes at the front.
  logic [W-1:0] q[$];
  int           m_fill;

  param_shift_reg #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .rot(rot),
    .sin_lo(sin_lo), .sin_hi(sin_hi), .par_in(par_in),
    .par_out(par_out), .sout_lo(sout_lo), .sout_hi(sout_hi),
    .fill(fill), .full(full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef SHIFT_REG_ROTATE_EN
  localparam bit ROT_BUILD = 1'b1;
`else
  localparam bit ROT_BUILD = 1'b0;
`endif

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [D*W-1:0] model_packed();
    logic [D*W-1:0] v = '0;
    for (int i = 0; i < D; i++) v[i*W +: W] = q[i];
    return v;
  endfunction

  task automatic model_reset();
    q.delete();
    for (int i = 0; i < D; i++) q.push_back('0);
    m_fill = 0;
  endtask

  task automatic model_update();
    logic [W-1:0] w;
    if (!rst_n) begin
      model_reset();
    end else if (en) begin
      if (mode == 2'b01) begin
        w = (ROT_BUILD && rot) ? q[D-1] : sin_lo;
        void'(q.pop_back());
        q.push_front(w);
        m_fill = (m_fill < D) ? m_fill + 1 : D;
      end else if (mode == 2'b10) begin
        w = (ROT_BUILD && rot) ? q[0] : sin_hi;
        void'(q.pop_front());
        q.push_back(w);
        m_fill = (m_fill < D) ? m_fill + 1 : D;
      end else if (mode == 2'b11) begin
        for (int i = 0; i < D; i++) q[i] = par_in[i*W +: W];
        m_fill = D;
      end
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".par_out"}, 64'(par_out), 64'(model_packed()));
    check({tag, ".fill"},    64'(fill),    64'(m_fill));
    check({tag, ".full"},    64'(full),    64'(m_fill == D));
    check({tag, ".sout_lo"}, 64'(sout_lo), 64'(q[0]));
    check({tag, ".sout_hi"}, 64'(sout_hi), 64'(q[D-1]));
  endtask

  // Drive inputs, clock one edge, advance the model, then compare 1 time unit later.
  task automatic step(input logic r, input logic e, input logic [1:0] m, input logic ro,
                      input logic [W-1:0] lo, input logic [W-1:0] hi, input logic [D*W-1:0] p,
                      input string tag);
    rst_n = r; en = e; mode = m; rot = ro; sin_lo = lo; sin_hi = hi; par_in = p;
    @(posedge clk);
    model_update();
    #1;
    check_model(tag);
  endtask

  initial begin
    logic [W-1:0] seq [4];
    seq = '{8'h11, 8'h22, 8'h33, 8'h44};
    rst_n = 1'b0; en = 1'b0; mode = 2'b00; rot = 1'b0;
    sin_lo = '0; sin_hi = '0; par_in = '0;
    model_reset();
    @(negedge clk);

    // 1. Reset after a load
    step(1, 1, 2'b11, 0, 8'h00, 8'h00, 32'hA1B2C3D4, "load0");
    step(0, 1, 2'b00, 0, 8'h00, 8'h00, 32'h0, "reset");
    check("reset.par_out_const", 64'(par_out), 64'h0);
    check("reset.fill_const", 64'(fill), 64'd0);

    // 2. Shift-up fill and saturation
    for (int i = 0; i < 4; i++) begin
      step(1, 1, 2'b01, 0, seq[i], 8'h00, 32'h0, "fill_up");
      check("fill_up.fill_const", 64'(fill), 64'(i + 1));
    end
    check("fill_up.full_const", 64'(full), 64'd1);
    check("fill_up.par_const", 64'(par_out), 64'h11223344);
    step(1, 1, 2'b01, 0, 8'h55, 8'h00, 32'h0, "sat");
    check("sat.par_const", 64'(par_out), 64'h22334455);
    check("sat.fill_const", 64'(fill), 64'd4);

    // 3. Load, then shift-down
    step(1, 1, 2'b11, 0, 8'h00, 8'h00, 32'hA1B2C3D4, "load1");
    check("load1.par_const", 64'(par_out), 64'hA1B2C3D4);
    check("down.sout_lo_before", 64'(sout_lo), 64'hD4);
    step(1, 1, 2'b10, 0, 8'h00, 8'hEE, 32'h0, "down");
    check("down.par_const", 64'(par_out), 64'hEEA1B2C3);

    // 4. Enable gating, including X on mode while disabled
    step(1, 1, 2'b11, 0, 8'h00, 8'h00, 32'h01020304, "load2");
    for (int i = 0; i < 3; i++) step(1, 0, 2'b01, 0, W'(8'h60 + i), 8'h00, 32'h0, "gated");
    check("gated.par_const", 64'(par_out), 64'h01020304);
    step(1, 0, 2'bxx, 0, 8'h77, 8'h88, 32'hDEADBEEF, "gated_x");

    // 5. Rotate select
    step(1, 1, 2'b11, 0, 8'h00, 8'h00, 32'h01020304, "load3");
    step(1, 1, 2'b01, 1, 8'h00, 8'h00, 32'h0, "rot_up");
    check("rot_up.par_const", 64'(par_out), ROT_BUILD ? 64'h02030401 : 64'h02030400);
    step(1, 1, 2'b10, 1, 8'h00, 8'h99, 32'h0, "rot_down");

    // 6. Reset priority over a load
    step(0, 1, 2'b11, 0, 8'h00, 8'h00, 32'hFFFFFFFF, "rst_prio");
    check("rst_prio.par_const", 64'(par_out), 64'h0);
    step(1, 1, 2'b11, 0, 8'h00, 8'h00, 32'hFFFFFFFF, "rst_rel");
    check("rst_rel.par_const", 64'(par_out), 64'hFFFFFFFF);
    check("rst_rel.fill_const", 64'(fill), 64'd4);

    // Random phase, starting from an empty register
    step(0, 0, 2'b00, 0, 8'h00, 8'h00, 32'h0, "rand_rst");
    for (int n = 0; n < 300; n++) begin
      step(($urandom_range(0, 19) != 0), ($urandom_range(0, 3) != 0), 2'($urandom),
           1'($urandom), W'($urandom), W'($urandom), $urandom, "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
